// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction one-hot codes, address field layout,
// routing-mode encodings and the dimension-order route function.
package noc_pkg;

  localparam logic [4:0] DIR_L  = 5'b10000;
  localparam logic [4:0] DIR_R  = 5'b01000;
  localparam logic [4:0] DIR_U  = 5'b00100;
  localparam logic [4:0] DIR_D  = 5'b00010;
  localparam logic [4:0] DIR_PE = 5'b00001;
  localparam logic [4:0] DIR_NONE = 5'b00000;

  localparam int ADDR_X_MSB = 15;
  localparam int ADDR_X_LSB = 8;
  localparam int ADDR_Y_MSB = 7;
  localparam int ADDR_Y_LSB = 0;

  localparam int ROUTE_XY = 0;
  localparam int ROUTE_YX = 1;

  // Unsigned per-axis compare; the mode only picks which axis is resolved first.
  function automatic logic [4:0] route_dir(input logic [15:0] cur,
                                           input logic [15:0] dest,
                                           input int          mode);
    logic [7:0] cur_x, cur_y, dest_x, dest_y;
    logic [4:0] x_dir, y_dir;
    cur_x  = cur[ADDR_X_MSB:ADDR_X_LSB];
    cur_y  = cur[ADDR_Y_MSB:ADDR_Y_LSB];
    dest_x = dest[ADDR_X_MSB:ADDR_X_LSB];
    dest_y = dest[ADDR_Y_MSB:ADDR_Y_LSB];
    x_dir  = (dest_x > cur_x) ? DIR_R : (dest_x < cur_x) ? DIR_L : DIR_NONE;
    y_dir  = (dest_y > cur_y) ? DIR_U : (dest_y < cur_y) ? DIR_D : DIR_NONE;
    if (mode == ROUTE_YX)
      route_dir = (y_dir != DIR_NONE) ? y_dir : (x_dir != DIR_NONE) ? x_dir : DIR_PE;
    else
      route_dir = (x_dir != DIR_NONE) ? x_dir : (y_dir != DIR_NONE) ? y_dir : DIR_PE;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with wrapping pointers; head is presented combinationally
// and forced to zero while empty so the output is clean after reset.
module noc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign do_push = push && (count_reg != FULL_COUNT);
  assign do_pop  = pop && (count_reg != '0);

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
  assign count = count_reg;

endmodule

// File: rtl/input_port_fifo.sv
// Router input port: buffers flits, requests the output chosen by
// dimension-order routing, and silently drops flits that would U-turn.
module input_port_fifo
  import noc_pkg::*;
#(
  parameter int          DATA_WIDTH      = 64,
  parameter int          BUFFER_DEPTH    = 4,
  parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
  parameter logic [4:0]  DIRECTION       = 5'b00001,
  parameter int          ROUTE_MODE      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            si,
  input  logic [DATA_WIDTH-1:0]           datai,
  output logic                            ri,
  output logic [4:0]                      req,
  input  logic [4:0]                      gnt,
  output logic [DATA_WIDTH-1:0]           datao,
  output logic [$clog2(BUFFER_DEPTH):0]   count,
  output logic                            uturn_err
);

  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] head;
  logic [4:0]            head_route;
  logic [4:0]            grant_hit;
  logic                  not_empty, uturn, do_push, do_pop;
  logic                  uturn_err_reg;

  noc_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .wdata (datai),
    .pop   (do_pop),
    .head  (head),
    .count (count)
  );

  // ri depends on the occupancy register alone, never on si or gnt.
  assign ri         = (count != FULL_COUNT);
  assign not_empty  = (count != '0);
  assign head_route = route_dir(CURRENT_ADDRESS, head[15:0], ROUTE_MODE);
  assign uturn      = not_empty && (head_route == DIRECTION) && (DIRECTION != DIR_PE);
  assign req        = (not_empty && !uturn) ? head_route : DIR_NONE;

  for (genvar gi = 0; gi < 5; gi++) begin : g_grant
    assign grant_hit[gi] = gnt[gi] & req[gi];
  end

  assign do_push = si && ri;
  assign do_pop  = (grant_hit != 5'b0) || uturn;

  always_ff @(posedge clk) begin
    if (rst)
      uturn_err_reg <= 1'b0;
    else if (uturn)
      uturn_err_reg <= 1'b1;
  end

  assign uturn_err = uturn_err_reg;
  assign datao     = head;

endmodule

// File: tb/tb_input_port_fifo.sv
// Self-checking bench: directed scenarios on three parameterisations plus a
// randomized run against a queue-based reference model.
module tb_input_port_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        si;
  logic [63:0] datai;
  logic [4:0]  gnt, gnt_yx, gnt_r;

  logic        ri, ri_yx, ri_r;
  logic [4:0]  req, req_yx, req_r;
  logic [63:0] datao, datao_yx, datao_r;
  logic [2:0]  count, count_yx, count_r;
  logic        uturn_err, uturn_err_yx, uturn_err_r;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  input_port_fifo #(.DATA_WIDTH(64), .BUFFER_DEPTH(4), .CURRENT_ADDRESS(16'h0101),
                    .DIRECTION(5'b00001), .ROUTE_MODE(0)) dut (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri), .req(req), .gnt(gnt),
    .datao(datao), .count(count), .uturn_err(uturn_err));

  input_port_fifo #(.DATA_WIDTH(64), .BUFFER_DEPTH(4), .CURRENT_ADDRESS(16'h0101),
                    .DIRECTION(5'b00001), .ROUTE_MODE(1)) dut_yx (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri_yx), .req(req_yx), .gnt(gnt_yx),
    .datao(datao_yx), .count(count_yx), .uturn_err(uturn_err_yx));

  input_port_fifo #(.DATA_WIDTH(64), .BUFFER_DEPTH(4), .CURRENT_ADDRESS(16'h0101),
                    .DIRECTION(5'b01000), .ROUTE_MODE(0)) dut_r (
    .clk(clk), .rst(rst), .si(si), .datai(datai), .ri(ri_r), .req(req_r), .gnt(gnt_r),
    .datao(datao_r), .count(count_r), .uturn_err(uturn_err_r));

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; si = 1'b0; gnt = '0; gnt_yx = '0; gnt_r = '0; datai = '0;
    step();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] mk_flit(input logic [15:0] dest);
    logic [63:0] f;
    f = {$urandom(), $urandom()};
    f[15:0] = dest;
    return f;
  endfunction

  // Reference route for a router at (1,1): signed axis offsets, axis order by mode.
  function automatic logic [4:0] exp_route(input logic [15:0] dest, input bit yx);
    int dx, dy;
    dx = int'(dest[15:8]) - 1;
    dy = int'(dest[7:0]) - 1;
    if (yx) begin
      if (dy > 0) return 5'b00100;
      if (dy < 0) return 5'b00010;
      if (dx > 0) return 5'b01000;
      if (dx < 0) return 5'b10000;
    end else begin
      if (dx > 0) return 5'b01000;
      if (dx < 0) return 5'b10000;
      if (dy > 0) return 5'b00100;
      if (dy < 0) return 5'b00010;
    end
    return 5'b00001;
  endfunction

  logic [63:0] flits [4];
  logic [63:0] f, extra;
  logic [63:0] q [$];
  logic [15:0] dests [4] = '{16'h0301, 16'h0001, 16'h0105, 16'h0100};
  logic [4:0]  er;
  logic        pop_m, push_m;

  initial begin
    rst = 1'b1; si = 1'b0; gnt = '0; gnt_yx = '0; gnt_r = '0; datai = '0;
    do_reset();
    $display("reset: checking idle state");
    check_value("rst_count", 64'(count), 0);
    check_value("rst_ri", 64'(ri), 1);
    check_value("rst_req", 64'(req), 0);
    check_value("rst_datao", datao, 0);
    check_value("rst_uturn", 64'(uturn_err), 0);
    check_value("rst_ri_yx", 64'(ri_yx), 1);
    check_value("rst_uturn_yx", 64'(uturn_err_yx), 0);
    check_value("rst_ri_r", 64'(ri_r), 1);
    check_value("rst_uturn_r", 64'(uturn_err_r), 0);

    // Single flit through an empty FIFO.
    f = mk_flit(16'h0301);
    si = 1'b1; datai = f;
    step();
    si = 1'b0;
    $display("single: pushed %h", f);
    check_value("single_req", 64'(req), 64'(5'b01000));
    check_value("single_datao", datao, f);
    check_value("single_count", 64'(count), 1);
    gnt = 5'b01000;
    step();
    gnt = '0;
    check_value("single_req_after_pop", 64'(req), 0);
    check_value("single_count_after_pop", 64'(count), 0);

    // Fill to full, drop an extra, drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      flits[i] = mk_flit(dests[i]);
      si = 1'b1; datai = flits[i];
      step();
      $display("fill: pushed %h", flits[i]);
    end
    check_value("full_ri", 64'(ri), 0);
    check_value("full_count", 64'(count), 4);
    extra = mk_flit(16'h0301);
    datai = extra;
    step();
    si = 1'b0;
    check_value("full_drop_count", 64'(count), 4);
    for (int i = 0; i < 4; i++) begin
      check_value("drain_datao", datao, flits[i]);
      check_value("drain_req", 64'(req), 64'(exp_route(dests[i], 1'b0)));
      gnt = exp_route(dests[i], 1'b0);
      step();
      $display("drain: popped %h", flits[i]);
    end
    gnt = '0;
    check_value("drain_count", 64'(count), 0);
    check_value("drain_ri", 64'(ri), 1);

    // Routing modes on XY and YX instances.
    do_reset();
    f = mk_flit(16'h0203);
    si = 1'b1; datai = f;
    step();
    si = 1'b0;
    $display("route: pushed %h", f);
    check_value("route_xy", 64'(req), 64'(5'b01000));
    check_value("route_yx", 64'(req_yx), 64'(5'b00100));
    check_value("route_yx_datao", datao_yx, f);
    gnt = 5'b01000; gnt_yx = 5'b00100;
    step();
    gnt = '0; gnt_yx = '0;
    f = mk_flit(16'h0101);
    si = 1'b1; datai = f;
    step();
    si = 1'b0;
    check_value("route_pe_xy", 64'(req), 64'(5'b00001));
    check_value("route_pe_yx", 64'(req_yx), 64'(5'b00001));
    check_value("route_yx_count", 64'(count_yx), 1);

    // Simultaneous push and pop at count=3 across pointer wrap.
    do_reset();
    q.delete();
    for (int i = 0; i < 3; i++) begin
      f = mk_flit(16'h0301);
      si = 1'b1; datai = f;
      step();
      q.push_back(f);
    end
    for (int k = 0; k < 6; k++) begin
      f = mk_flit(16'h0301);
      si = 1'b1; datai = f; gnt = 5'b01000;
      check_value("pp_count", 64'(count), 3);
      check_value("pp_ri", 64'(ri), 1);
      check_value("pp_datao", datao, q[0]);
      step();
      $display("pushpop: popped %h pushed %h", q[0], f);
      void'(q.pop_front());
      q.push_back(f);
    end
    si = 1'b0; gnt = '0;
    check_value("pp_final_count", 64'(count), 3);
    check_value("pp_final_datao", datao, q[0]);

    // U-turn drop on the R-side instance.
    do_reset();
    f = mk_flit(16'h0301);
    si = 1'b1; datai = f;
    step();
    si = 1'b0;
    $display("uturn: pushed %h", f);
    check_value("uturn_req", 64'(req_r), 0);
    check_value("uturn_count_head", 64'(count_r), 1);
    step();
    check_value("uturn_count_popped", 64'(count_r), 0);
    check_value("uturn_err_set", 64'(uturn_err_r), 1);
    f = mk_flit(16'h0001);
    si = 1'b1; datai = f;
    step();
    si = 1'b0;
    check_value("uturn_next_req", 64'(req_r), 64'(5'b10000));
    check_value("uturn_next_datao", datao_r, f);
    check_value("uturn_err_sticky", 64'(uturn_err_r), 1);
    step();
    check_value("uturn_err_sticky2", 64'(uturn_err_r), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_value("uturn_err_cleared", 64'(uturn_err_r), 0);
    check_value("uturn_rst_count", 64'(count_r), 0);

    // Mismatched grant, then reset mid-stream with si and gnt active.
    do_reset();
    f = mk_flit(16'h0301);
    si = 1'b1; datai = f;
    step();
    si = 1'b0; gnt = 5'b10000;
    step();
    gnt = '0;
    $display("mismatch: held %h", f);
    check_value("mismatch_count", 64'(count), 1);
    check_value("mismatch_req", 64'(req), 64'(5'b01000));
    si = 1'b1; datai = mk_flit(16'h0301);
    step();
    check_value("mismatch_count2", 64'(count), 2);
    rst = 1'b1; si = 1'b1; gnt = 5'b01000;
    step();
    rst = 1'b0; si = 1'b0; gnt = '0;
    check_value("midrst_count", 64'(count), 0);
    check_value("midrst_ri", 64'(ri), 1);
    check_value("midrst_req", 64'(req), 0);

    // Randomized traffic against the queue model (XY, PE side: no U-turns).
    do_reset();
    q.delete();
    for (int c = 0; c < 400; c++) begin
      er = (q.size() == 0) ? 5'b00000 : exp_route(q[0][15:0], 1'b0);
      check_value("rnd_count", 64'(count), 64'(q.size()));
      check_value("rnd_ri", 64'(ri), 64'(q.size() < 4));
      check_value("rnd_req", 64'(req), 64'(er));
      if (q.size() != 0)
        check_value("rnd_datao", datao, q[0]);
      si    = 1'($urandom_range(0, 1));
      datai = mk_flit({8'($urandom_range(0, 2)), 8'($urandom_range(0, 2))});
      case ($urandom_range(0, 3))
        0:       gnt = 5'b00000;
        1:       gnt = 5'($urandom_range(0, 31));
        default: gnt = er;
      endcase
      pop_m  = (q.size() != 0) && ((gnt & er) != 5'b0);
      push_m = si && (q.size() < 4);
      step();
      if (pop_m) begin
        $display("rnd: popped %h", q[0]);
        void'(q.pop_front());
      end
      if (push_m)
        q.push_back(datai);
    end
    si = 1'b0; gnt = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
